// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and flag definitions for the alu_seq instruction sequencer.
// Optional build macro used elsewhere in this slice: ALU_SEQ_CNT_EN (retired instruction counter).
package alu_seq_pkg;

    localparam int OP_W     = 4;
    localparam int FLG_W    = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_NEG  = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD       = 4'd0,
        OP_SUB       = 4'd1,
        OP_AND       = 4'd2,
        OP_OR        = 4'd3,
        OP_XOR       = 4'd4,
        OP_INC       = 4'd5,
        OP_MOVA      = 4'd6,
        OP_MOVB      = 4'd7,
        OP_LOADI     = 4'd8,
        OP_ILL_FIRST = 4'd9,
        OP_ILL_LAST  = 4'd15
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    // Every opcode with the top bit clear is executed by the external ALU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return !op[OP_W-1];
    endfunction

    function automatic logic is_loadi(input logic [OP_W-1:0] op);
        return op == OP_LOADI;
    endfunction

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op >= OP_ILL_FIRST) && (op <= OP_ILL_LAST);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x BW register file: two operand read ports, one debug read port, one synchronous write port.
// Kept in flops rather than block RAM because the reads are combinational and reset clears every entry.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int BW   = 16,
    parameter int NREG = 4,
    parameter int RA   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RA-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [RA-1:0] ra_addr,
    output logic [BW-1:0] ra_data,
    input  logic [RA-1:0] rb_addr,
    output logic [BW-1:0] rb_data,
    input  logic [RA-1:0] rd_addr,
    output logic [BW-1:0] rd_data
);

    logic [BW-1:0] regs_q [NREG];
    logic [BW-1:0] regs_d [NREG];

    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        assign regs_d[gi] = (we && (waddr == RA'(gi))) ? wdata : regs_q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_seq.sv
// Two-state instruction sequencer feeding an external combinational ALU and writing results back.
// Define ALU_SEQ_CNT_EN to add the 16-bit retired_cnt output.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int BW   = 16,
    parameter int NREG = 4,
    parameter int RA   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [RA-1:0]     instr_dst,
    input  logic [RA-1:0]     instr_sa,
    input  logic [RA-1:0]     instr_sb,
    input  logic [BW-1:0]     instr_imm,
    output logic [BW-1:0]     alu_a,
    output logic [BW-1:0]     alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [BW-1:0]     alu_out,
    input  logic [FLG_W-1:0]  alu_flags,
    output logic [FLG_W-1:0]  flags,
    output logic              err,
    input  logic [RA-1:0]     rd_addr,
    output logic [BW-1:0]     rd_data
`ifdef ALU_SEQ_CNT_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [RA-1:0]     dst_q, dst_d;
    logic [BW-1:0]     imm_q, imm_d;
    logic [BW-1:0]     alu_a_q, alu_a_d;
    logic [BW-1:0]     alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic [FLG_W-1:0]  flags_q, flags_d;
    logic              err_q, err_d;

    logic              rf_we;
    logic [BW-1:0]     rf_wdata;
    logic [BW-1:0]     ra_data, rb_data;
    logic              commit;

    assign commit   = (state_q == S_EXEC);
    assign rf_we    = commit && !is_illegal(op_q);
    assign rf_wdata = is_loadi(op_q) ? imm_q : alu_out;

    alu_seq_regfile #(
        .BW   (BW),
        .NREG (NREG),
        .RA   (RA)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (dst_q),
        .wdata   (rf_wdata),
        .ra_addr (instr_sa),
        .ra_data (ra_data),
        .rb_addr (instr_sb),
        .rb_data (rb_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        op_d         = op_q;
        dst_d        = dst_q;
        imm_d        = imm_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        flags_d      = flags_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && ready_q) begin
                    op_d    = instr_op;
                    dst_d   = instr_dst;
                    imm_d   = instr_imm;
                    alu_a_d = ra_data;
                    alu_b_d = rb_data;
                    // LOADI and illegal opcodes park the ALU on ADD (0000).
                    alu_opcode_d = is_alu_op(instr_op) ? instr_op : OP_ADD;
                    state_d = S_EXEC;
                    ready_d = 1'b0;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (is_alu_op(op_q)) begin
                    flags_d[FLG_OVF]  = alu_flags[FLG_OVF];
                    flags_d[FLG_NEG]  = alu_flags[FLG_NEG];
                    flags_d[FLG_ZERO] = alu_flags[FLG_ZERO];
                end
                if (is_illegal(op_q)) err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

`ifdef ALU_SEQ_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d       = commit ? cnt_q + 16'd1 : cnt_q;
    assign retired_cnt = cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            op_q         <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            flags_q      <= '0;
            err_q        <= 1'b0;
`ifdef ALU_SEQ_CNT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            imm_q        <= imm_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            flags_q      <= flags_d;
            err_q        <= err_d;
`ifdef ALU_SEQ_CNT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign instr_ready = ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign flags       = flags_q;
    assign err         = err_q;

endmodule
